// File: rtl/ps2_vga_pkg.sv
// ---------------------------------------------------------------------------
// ps2_vga_pkg
// Shared definitions for the PS/2 keyboard to VGA text path.
//   - PS/2 set-2 special byte values (break prefix, extended prefix,
//     backspace, enter).
//   - GLYPH_W: width of a 5x5 glyph bitmap (bit 24 = top-left).
//   - ps2_state_e: byte-stream parser states.
// ---------------------------------------------------------------------------
package ps2_vga_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BKSP  = 8'h66;
    localparam logic [7:0] PS2_ENTER = 8'h5A;
    localparam int         GLYPH_W   = 25;

    // Parser state. IDLE is the only state in which a byte can edit the buffer.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        EXT       = 2'd2,
        EXT_BREAK = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/glyph_rom.sv
// ---------------------------------------------------------------------------
// glyph_rom
// Combinational PS/2 set-2 scan code -> 5x5 bitmap lookup.
// Letters A-Z and digits 0-9 have non-zero glyphs; every other code maps to
// zero, so "glyph != 0" is the single definition of a printable key.
// Ports:
//   code   in   8        scan code byte
//   glyph  out  GLYPH_W  bitmap, rows of 5 bits, bit 24 = top-left
// ---------------------------------------------------------------------------
module glyph_rom
    import ps2_vga_pkg::*;
(
    input  logic [7:0]         code,
    output logic [GLYPH_W-1:0] glyph
);

    always_comb begin
        glyph = '0;
        case (code)
            8'h1C: glyph = 25'b01010_01010_01110_01010_01110; // A
            8'h32: glyph = 25'b11110_10001_11110_10001_11110; // B
            8'h21: glyph = 25'b01111_10000_10000_10000_01111; // C
            8'h23: glyph = 25'b11110_10001_10001_10001_11110; // D
            8'h24: glyph = 25'b11111_10000_11110_10000_11111; // E
            8'h2B: glyph = 25'b11111_10000_11110_10000_10000; // F
            8'h34: glyph = 25'b01111_10000_10011_10001_01111; // G
            8'h33: glyph = 25'b10001_10001_11111_10001_10001; // H
            8'h43: glyph = 25'b01110_00100_00100_00100_01110; // I
            8'h3B: glyph = 25'b00111_00010_00010_10010_01100; // J
            8'h42: glyph = 25'b10010_10100_11000_10100_10010; // K
            8'h4B: glyph = 25'b10000_10000_10000_10000_11111; // L
            8'h3A: glyph = 25'b10001_11011_10101_10001_10001; // M
            8'h31: glyph = 25'b10001_11001_10101_10011_10001; // N
            8'h44: glyph = 25'b01110_10001_10001_10001_01110; // O
            8'h4D: glyph = 25'b11110_10001_11110_10000_10000; // P
            8'h15: glyph = 25'b01110_10001_10101_10010_01101; // Q
            8'h2D: glyph = 25'b11110_10001_11110_10100_10010; // R
            8'h1B: glyph = 25'b01111_10000_01110_00001_11110; // S
            8'h2C: glyph = 25'b11111_00100_00100_00100_00100; // T
            8'h3C: glyph = 25'b10001_10001_10001_10001_01110; // U
            8'h2A: glyph = 25'b10001_10001_10001_01010_00100; // V
            8'h1D: glyph = 25'b10001_10001_10101_11011_10001; // W
            8'h22: glyph = 25'b10001_01010_00100_01010_10001; // X
            8'h35: glyph = 25'b10001_01010_00100_00100_00100; // Y
            8'h1A: glyph = 25'b11111_00010_00100_01000_11111; // Z
            8'h45: glyph = 25'b01110_10011_10101_11001_01110; // 0
            8'h16: glyph = 25'b00100_01100_00100_00100_01110; // 1
            8'h1E: glyph = 25'b01110_00010_01110_01000_01110; // 2
            8'h26: glyph = 25'b01110_00010_00110_00010_01110; // 3
            8'h25: glyph = 25'b01010_01010_01110_00010_00010; // 4
            8'h2E: glyph = 25'b01110_01000_01110_00010_01110; // 5
            8'h36: glyph = 25'b01110_01000_01110_01010_01110; // 6
            8'h3D: glyph = 25'b01110_00010_00100_01000_01000; // 7
            8'h3E: glyph = 25'b01110_01010_01110_01010_01110; // 8
            8'h46: glyph = 25'b01110_01010_01110_00010_01110; // 9
            default: glyph = '0;
        endcase
    end

endmodule

// File: rtl/ps2_text_buffer.sv
// ---------------------------------------------------------------------------
// ps2_text_buffer
// Parses a PS/2 set-2 byte stream (F0 break and E0 extended prefixes),
// keeps printable make codes in a DEPTH-slot circular line buffer with
// backspace and enter (clear), and serves 5x5 glyphs by logical index to
// the VGA side with one cycle of registered latency.
//
// Build option: PS2_TEXT_SCROLL_EN
//   defined   - append to a full buffer overwrites the oldest character
//   undefined - append to a full buffer is dropped
//   overflow pulses in both cases.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   code_valid   in   1      code is valid this cycle
//   code         in   8      scan code byte
//   rd_idx       in   IDX_W  logical index, 0 = oldest character
//   rd_glyph     out  25     registered bitmap of slot rd_idx (0 if empty)
//   rd_occupied  out  1      registered, rd_idx < count
//   count        out  CNT_W  stored character count
//   full         out  1      count == DEPTH
//   overflow     out  1      one-cycle pulse: append hit a full buffer
//   dbg_state    out  2      parser state (ps2_state_e encoding)
//
// Handshake: code is sampled on every rising edge where code_valid is 1;
// there is no back-pressure, so the block accepts one byte per cycle.
// ---------------------------------------------------------------------------
module ps2_text_buffer
    import ps2_vga_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               code_valid,
    input  logic [7:0]         code,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [GLYPH_W-1:0] rd_glyph,
    output logic               rd_occupied,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               overflow,
    output logic [1:0]         dbg_state
);

    // Wide enough to hold start + count or start + rd_idx without overflow.
    localparam int SUM_W = IDX_W + 2;

    ps2_state_e         state_q, state_d;
    logic [IDX_W-1:0]   start_q, start_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [GLYPH_W-1:0] rd_glyph_q, rd_glyph_d;
    logic               rd_occ_q, rd_occ_d;
    logic [7:0]         mem_q [DEPTH];

    logic               mem_we;
    logic [SUM_W-1:0]   wr_sum, rd_sum;
    logic [IDX_W-1:0]   wr_ptr, rd_addr, start_inc;
    logic               full_w;
    logic [GLYPH_W-1:0] code_glyph, rd_rom;

    // Printable test and read-side conversion share the same ROM.
    glyph_rom u_code_rom (
        .code  (code),
        .glyph (code_glyph)
    );

    glyph_rom u_rd_rom (
        .code  (mem_q[rd_addr]),
        .glyph (rd_rom)
    );

    assign full_w = (count_q == CNT_W'(DEPTH));

    // Circular addressing by compare-and-subtract so DEPTH need not be a
    // power of two. With a full buffer the write slot wraps onto start.
    always_comb begin
        wr_sum = SUM_W'(start_q) + SUM_W'(count_q);
        if (wr_sum >= SUM_W'(DEPTH)) begin
            wr_ptr = IDX_W'(wr_sum - SUM_W'(DEPTH));
        end else begin
            wr_ptr = IDX_W'(wr_sum);
        end

        rd_sum = SUM_W'(start_q) + SUM_W'(rd_idx);
        if (rd_sum >= SUM_W'(DEPTH)) begin
            rd_addr = IDX_W'(rd_sum - SUM_W'(DEPTH));
        end else begin
            rd_addr = IDX_W'(rd_sum);
        end

        if (start_q == IDX_W'(DEPTH - 1)) begin
            start_inc = '0;
        end else begin
            start_inc = start_q + IDX_W'(1);
        end
    end

    // Parser and buffer-control next state.
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        mem_we     = 1'b0;

        if (code_valid) begin
            case (state_q)
                IDLE: begin
                    if (code == PS2_BREAK) begin
                        state_d = BREAK;
                    end else if (code == PS2_EXT) begin
                        state_d = EXT;
                    end else if (code == PS2_BKSP) begin
                        if (count_q != '0) begin
                            count_d = count_q - CNT_W'(1);
                        end
                    end else if (code == PS2_ENTER) begin
                        count_d = '0;
                        start_d = '0;
                    end else if (code_glyph != '0) begin
                        if (!full_w) begin
                            mem_we  = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            overflow_d = 1'b1;
`ifdef PS2_TEXT_SCROLL_EN
                            // Overwrite the oldest slot and slide the window.
                            mem_we  = 1'b1;
                            start_d = start_inc;
`endif
                        end
                    end
                end
                BREAK: begin
                    state_d = IDLE;
                end
                EXT: begin
                    state_d = (code == PS2_BREAK) ? EXT_BREAK : IDLE;
                end
                EXT_BREAK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Read path samples pre-update count and storage.
    always_comb begin
        rd_occ_d   = (SUM_W'(rd_idx) < SUM_W'(count_q));
        rd_glyph_d = rd_occ_d ? rd_rom : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            start_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_glyph_q <= '0;
            rd_occ_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_glyph_q <= rd_glyph_d;
            rd_occ_q   <= rd_occ_d;
        end
    end

    // Storage content is never observed beyond count, so it has no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr] <= code;
        end
    end

    assign rd_glyph    = rd_glyph_q;
    assign rd_occupied = rd_occ_q;
    assign count       = count_q;
    assign full        = full_w;
    assign overflow    = overflow_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_text_buffer.sv
module tb_ps2_text_buffer;

  localparam int DEPTH = 5;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [24:0] G_A = 25'b01010_01010_01110_01010_01110;
  localparam logic [24:0] G_B = 25'b11110_10001_11110_10001_11110;
  localparam logic [24:0] G_C = 25'b01111_10000_10000_10000_01111;
  localparam logic [24:0] G_Q = 25'b01110_10001_10101_10010_01101;
  localparam logic [24:0] G_1 = 25'b00100_01100_00100_00100_01110;
  localparam logic [24:0] G_2 = 25'b01110_00010_01110_01000_01110;
  localparam logic [24:0] G_5 = 25'b01110_01000_01110_00010_01110;
  localparam logic [24:0] G_6 = 25'b01110_01000_01110_01010_01110;

`ifdef PS2_TEXT_SCROLL_EN
  localparam logic [24:0] G_OLD0 = G_2;
  localparam logic [24:0] G_OLD4 = G_6;
`else
  localparam logic [24:0] G_OLD0 = G_1;
  localparam logic [24:0] G_OLD4 = G_5;
`endif

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              code_valid = 1'b0;
  logic [7:0]        code = 8'h00;
  logic [IDX_W-1:0]  rd_idx = '0;
  logic [24:0]       rd_glyph;
  logic              rd_occupied;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              overflow;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  ps2_text_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .code_valid  (code_valid),
    .code        (code),
    .rd_idx      (rd_idx),
    .rd_glyph    (rd_glyph),
    .rd_occupied (rd_occupied),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic             rst;
    logic             v;
    logic [7:0]       code;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             ovf;
    logic             occ;
    logic [24:0]      glyph;
    logic [1:0]       st;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expected outputs are those seen one half-cycle after the edge that
  // consumed the vector's inputs.
  task automatic add(input logic r, input logic v, input logic [7:0] c,
                     input int idx, input int cnt, input logic f,
                     input logic o, input logic occ, input logic [24:0] g,
                     input int st);
    vec_t t;
    t.rst = r; t.v = v; t.code = c; t.idx = IDX_W'(idx);
    t.cnt = CNT_W'(cnt); t.full = f; t.ovf = o; t.occ = occ;
    t.glyph = g; t.st = 2'(st);
    vq.push_back(t);
  endtask

  // ---------------- driver + scoreboard ----------------
  task automatic apply(input vec_t t, input string tag);
    rst        = t.rst;
    code_valid = t.v;
    code       = t.code;
    rd_idx     = t.idx;
    @(negedge clk);
    n_vec++;
    if (count !== t.cnt || full !== t.full || overflow !== t.ovf ||
        rd_occupied !== t.occ || rd_glyph !== t.glyph || dbg_state !== t.st) begin
      n_bad++;
      $display("FAIL %s #%0d: got cnt=%0d full=%0b ovf=%0b occ=%0b glyph=%b st=%0d; want cnt=%0d full=%0b ovf=%0b occ=%0b glyph=%b st=%0d",
               tag, n_vec, count, full, overflow, rd_occupied, rd_glyph, dbg_state,
               t.cnt, t.full, t.ovf, t.occ, t.glyph, t.st);
    end
  endtask

  initial begin
    // T1: basic appends and reads
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, '0,  0);
    add(0, 1, 8'h1C, 0, 1, 0, 0, 0, '0,  0);
    add(0, 1, 8'h32, 0, 2, 0, 0, 1, G_A, 0);
    add(0, 1, 8'h21, 0, 3, 0, 0, 1, G_A, 0);
    add(0, 0, 8'h00, 0, 3, 0, 0, 1, G_A, 0);
    add(0, 0, 8'h00, 3, 3, 0, 0, 0, '0,  0);
    add(0, 0, 8'h00, 1, 3, 0, 0, 1, G_B, 0);
    add(0, 0, 8'h00, 2, 3, 0, 0, 1, G_C, 0);
    // T2: break and extended prefixes
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, '0,  0);
    add(0, 1, 8'h1C, 0, 1, 0, 0, 0, '0,  0);
    add(0, 1, 8'hF0, 0, 1, 0, 0, 1, G_A, 1);
    add(0, 1, 8'h1C, 0, 1, 0, 0, 1, G_A, 0);
    add(0, 1, 8'hE0, 0, 1, 0, 0, 1, G_A, 2);
    add(0, 1, 8'h1C, 0, 1, 0, 0, 1, G_A, 0);
    add(0, 1, 8'hE0, 0, 1, 0, 0, 1, G_A, 2);
    add(0, 1, 8'hF0, 0, 1, 0, 0, 1, G_A, 3);
    add(0, 1, 8'h1C, 0, 1, 0, 0, 1, G_A, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, '0,  0);
    add(0, 1, 8'h12, 0, 1, 0, 0, 1, G_A, 0);  // non-printable: ignored
    // T3: backspace down to zero and beyond
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, '0,  0);
    add(0, 1, 8'h1C, 0, 1, 0, 0, 0, '0,  0);
    add(0, 1, 8'h32, 0, 2, 0, 0, 1, G_A, 0);
    add(0, 1, 8'h21, 0, 3, 0, 0, 1, G_A, 0);
    add(0, 1, 8'h66, 2, 2, 0, 0, 1, G_C, 0);
    add(0, 1, 8'h66, 0, 1, 0, 0, 1, G_A, 0);
    add(0, 1, 8'h66, 0, 0, 0, 0, 1, G_A, 0);
    add(0, 1, 8'h66, 0, 0, 0, 0, 0, '0,  0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 0, '0,  0);
    // T5: enter clears
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, '0,  0);
    add(0, 1, 8'h1C, 0, 1, 0, 0, 0, '0,  0);
    add(0, 1, 8'h32, 0, 2, 0, 0, 1, G_A, 0);
    add(0, 1, 8'h5A, 1, 0, 0, 0, 1, G_B, 0);
    add(0, 1, 8'h15, 0, 1, 0, 0, 0, '0,  0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 1, G_Q, 0);
    // T4: fill, overflow, wrap
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, '0,  0);
    add(0, 1, 8'h16, 0, 1, 0, 0, 0, '0,  0);
    add(0, 1, 8'h1E, 0, 2, 0, 0, 1, G_1, 0);
    add(0, 1, 8'h26, 0, 3, 0, 0, 1, G_1, 0);
    add(0, 1, 8'h25, 0, 4, 0, 0, 1, G_1, 0);
    add(0, 1, 8'h2E, 0, 5, 1, 0, 1, G_1, 0);
    add(0, 1, 8'h36, 0, 5, 1, 1, 1, G_1, 0);
    add(0, 0, 8'h00, 0, 5, 1, 0, 1, G_OLD0, 0);
    add(0, 0, 8'h00, 4, 5, 1, 0, 1, G_OLD4, 0);
    add(0, 1, 8'h66, 0, 4, 0, 0, 1, G_OLD0, 0);
    add(0, 1, 8'h16, 0, 5, 1, 0, 1, G_OLD0, 0);
    add(0, 0, 8'h00, 4, 5, 1, 0, 1, G_1, 0);
    add(0, 1, 8'h5A, 0, 0, 0, 0, 1, G_OLD0, 0);
    add(0, 1, 8'h1C, 0, 1, 0, 0, 0, '0,  0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 1, G_A, 0);

    @(negedge clk);
    foreach (vq[i]) apply(vq[i], "table");

    // T6: reset in the middle of a break sequence
    begin
      vec_t t;
      t = '{rst: 0, v: 1, code: 8'h1C, idx: '0, cnt: 3'(1), full: 0, ovf: 0, occ: 0, glyph: '0, st: 2'd0};
      t.rst = 1; t.v = 0; t.cnt = '0;
      apply(t, "t6_rst");
      t.rst = 0; t.v = 1; t.code = 8'h1C; t.cnt = CNT_W'(1);
      apply(t, "t6_a1");
      t.code = 8'hF0; t.occ = 1; t.glyph = G_A; t.st = 2'd1;
      apply(t, "t6_f0");
      t.rst = 1; t.v = 0; t.cnt = '0; t.occ = 0; t.glyph = '0; t.st = 2'd0;
      apply(t, "t6_midrst");
      t.rst = 0; t.v = 1; t.code = 8'h1C; t.cnt = CNT_W'(1);
      apply(t, "t6_after");
      t.v = 0; t.occ = 1; t.glyph = G_A;
      apply(t, "t6_read");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_text_buffer.md
Name: ps2_text_buffer

Overview:
- Sequential successor to the combinational scan-code-to-glyph decoder; sits between the PS/2 receiver and the VGA pixel generator.
- Parses the PS/2 set-2 byte stream, including the F0 break prefix and the E0 extended prefix.
- Stores printable make codes in a DEPTH-character line buffer and supports backspace and clear.
- Serves 5x5 glyph bitmaps (25 bits) by character index to the VGA side, with 1-cycle registered latency.

Parameters:
- DEPTH, 16: number of character slots; legal range 2..256, power of two not required.
- IDX_W, $clog2(DEPTH): localparam; width of indices and pointers.
- CNT_W, $clog2(DEPTH+1): localparam; width of count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- code_valid  in  1  one-cycle strobe; code is valid this cycle.
- code  in  8  PS/2 scan-code byte.
- rd_idx  in  IDX_W  logical character index; 0 = oldest stored character.
- rd_glyph  out  25  registered 5x5 bitmap of slot rd_idx; bit 24 = top-left.
- rd_occupied  out  1  registered; slot rd_idx currently holds a character.
- count  out  CNT_W  number of stored characters, 0..DEPTH.
- full  out  1  count == DEPTH.
- overflow  out  1  one-cycle pulse when an append hits a full buffer.

Behaviour:
- Reset: parser state IDLE; start pointer 0; count 0; rd_glyph 0; rd_occupied 0; overflow 0. Storage contents are don't-care; count gates all reads.
- Parser FSM advances only on cycles with code_valid=1.
  - IDLE:
    - F0 -> BREAK.
    - E0 -> EXT.
    - 66 (backspace) -> remove the newest character if count>0, otherwise no-op; stay IDLE.
    - 5A (enter) -> count := 0 and start := 0; stay IDLE.
    - Printable code (glyph_rom output non-zero: 26 letters, 10 digits) -> append; stay IDLE.
    - Any other byte -> ignored.
  - BREAK: any byte is consumed (the released key) -> IDLE. No append.
  - EXT: F0 -> EXT_BREAK; any other byte is discarded -> IDLE.
  - EXT_BREAK: any byte is consumed -> IDLE.
- Append:
  - Write position is (start+count) wrapped at DEPTH using compare-and-subtract, not bit truncation.
  - If not full: count increments.
  - If full: see Optional Feature. overflow pulses on the cycle after the code_valid cycle, in both builds.
- Storage holds raw scan codes (8 bits per slot); conversion to a bitmap happens on read through glyph_rom.
- Read:
  - Registered, latency 1.
  - rd_glyph(t+1) = glyph_rom(mem[(start+rd_idx) mod DEPTH]) if rd_idx<count(t), else 0.
  - rd_occupied(t+1) = (rd_idx<count(t)).
- Read and write in the same cycle: the read returns the pre-update state.
- count and full are registered and reflect an update one cycle after the code_valid cycle.
- rst asserted mid-sequence (e.g. after F0): FSM returns to IDLE immediately, and the buffer empties.

Optional Feature:
- Macro: PS2_TEXT_SCROLL_EN.
- Defined: appending to a full buffer overwrites the oldest slot; start advances by 1 with wrap; count stays DEPTH; overflow pulses.
- Undefined: appending to a full buffer is dropped; storage, start and count are unchanged; overflow pulses.

Decomposition:
- Shared package ps2_vga_pkg contains:
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_BKSP=8'h66, PS2_ENTER=8'h5A, GLYPH_W=25;
  - the parser state enum (IDLE, BREAK, EXT, EXT_BREAK).
- One sub-module, glyph_rom: combinational scan code -> 25-bit bitmap, with a zero default for non-printable codes.
- The printable test is glyph_rom output != 0, so the printable set has a single source of truth.

Test Plan:
1. Reset, then codes 1C, 32, 21 (A, B, C) -> count=3; rd_idx=0 returns 25'b0101001010011100101001110 one cycle later; rd_idx=3 returns 0 and rd_occupied=0.
2. 1C, F0, 1C -> count=1 (break byte not appended); then E0, 1C and E0, F0, 1C -> count still 1 and FSM back in IDLE.
3. Three appends, then 66, 66, 66, 66 -> count goes 3,2,1,0,0; the fourth backspace is a no-op with no underflow.
4. DEPTH=5: six appends of 16,1E,26,25,2E,36 (digits 1-6) -> full=1, overflow pulses once. SCROLL_EN build: rd_idx=0 returns digit 2's glyph 25'b0111000010011100100001110. Non-SCROLL build: rd_idx=0 returns digit 1's glyph, rd_idx=4 returns digit 5's glyph.
5. 1C, 32, then 5A -> count=0; the next append 15 (Q) reads back at rd_idx=0.
6. Assert rst right after F0 -> count=0; the following 1C is appended (count=1), proving the FSM left BREAK.
